// File: rtl/status_reg_decoder.sv
// Consumer for the 8-bit status word {int_en,2'b11,zero,carry,neg,parity}.
// It checks the framing bits, unpacks the fields, keeps sticky flags and holds an irq until it is acknowledged.
module status_reg_decoder #(
  parameter int         ERR_CNT_W   = 4,
  parameter logic [2:0] STICKY_MASK = 3'b111
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 stat_valid,
  output logic                 stat_ready,
  input  logic [7:0]           status,
  input  logic [2:0]           clr_sticky,
  input  logic                 err_clr,
  input  logic                 irq_ack,
  output logic                 int_en_o,
  output logic                 zero_o,
  output logic                 carry_o,
  output logic                 neg_o,
  output logic [1:0]           parity_o,
  output logic [2:0]           sticky,
  output logic                 irq,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, IRQ_ST} state_t;

  state_t     state;
  logic [7:0] word;
  logic       frame_ok;
  logic [2:0] flags;
  logic [2:0] new_flags;
  logic [2:0] sticky_set;
  logic       eval_bad;

  assign frame_ok   = (word[6:5] == 2'b11);
  assign flags      = word[4:2] & STICKY_MASK;
  assign new_flags  = flags & ~sticky;
  assign sticky_set = (state == EVAL && frame_ok) ? flags : 3'b000;
  assign eval_bad   = (state == EVAL) && !frame_ok;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      stat_ready <= 1'b1;
      word       <= 8'h00;
      int_en_o   <= 1'b0;
      zero_o     <= 1'b0;
      carry_o    <= 1'b0;
      neg_o      <= 1'b0;
      parity_o   <= 2'b00;
      sticky     <= 3'b000;
      irq        <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      frame_err <= 1'b0;
      // A flag being set in EVAL wins over a same-cycle clear of that bit.
      sticky    <= (sticky & ~clr_sticky) | sticky_set;

      if (err_clr)
        err_cnt <= '0;
      else if (eval_bad && err_cnt != {ERR_CNT_W{1'b1}})
        err_cnt <= err_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (stat_valid && stat_ready) begin
            word       <= status;
            state      <= EVAL;
            stat_ready <= 1'b0;
          end
        end
        EVAL: begin
          if (!frame_ok) begin
            frame_err  <= 1'b1;
            state      <= IDLE;
            stat_ready <= 1'b1;
          end else begin
            int_en_o <= word[7];
            zero_o   <= word[4];
            carry_o  <= word[3];
            neg_o    <= word[2];
            parity_o <= word[1:0];
            if (word[7] && new_flags != 3'b000) begin
              state <= IRQ_ST;
              irq   <= 1'b1;
            end else begin
              state      <= IDLE;
              stat_ready <= 1'b1;
            end
          end
        end
        IRQ_ST: begin
          if (irq_ack) begin
            irq        <= 1'b0;
            state      <= IDLE;
            stat_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          stat_ready <= 1'b1;
          irq        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_reg_decoder.sv
// Directed bench for status_reg_decoder: decode, sticky/irq, framing errors, and async reset.
module tb_status_reg_decoder;

  logic       clk;
  logic       rstN;
  logic       stat_valid;
  logic       stat_ready;
  logic [7:0] status;
  logic [2:0] clr_sticky;
  logic       err_clr;
  logic       irq_ack;
  logic       int_en_o, zero_o, carry_o, neg_o;
  logic [1:0] parity_o;
  logic [2:0] sticky;
  logic       irq;
  logic       frame_err;
  logic [3:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  status_reg_decoder #(.ERR_CNT_W(4), .STICKY_MASK(3'b111)) dut (
    .clk(clk), .rstN(rstN), .stat_valid(stat_valid), .stat_ready(stat_ready),
    .status(status), .clr_sticky(clr_sticky), .err_clr(err_clr), .irq_ack(irq_ack),
    .int_en_o(int_en_o), .zero_o(zero_o), .carry_o(carry_o), .neg_o(neg_o),
    .parity_o(parity_o), .sticky(sticky), .irq(irq), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for ready, then presents one word for one cycle; returns at the negedge after capture.
  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (stat_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (stat_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: stat_ready=%0b required 1", stat_ready);
    end
    stat_valid = 1'b1;
    status     = w;
    @(negedge clk);
    stat_valid = 1'b0;
    status     = 8'h00;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({stat_ready, irq, sticky, err_cnt, frame_err} !== 10'b1_0_000_0000_0) begin
      miscompares++;
      $display("FAIL reset_state: ready/irq/sticky/err_cnt/frame_err=%b required 1_0_000_0000_0",
               {stat_ready, irq, sticky, err_cnt, frame_err});
    end
    vectors++;
    if ({int_en_o, zero_o, carry_o, neg_o, parity_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_decode: decoded=%b required 000000",
               {int_en_o, zero_o, carry_o, neg_o, parity_o});
    end
    rstN = 1'b1;
  endtask

  task automatic test_decode();
    send_word(8'hE0);
    @(negedge clk);
    vectors++;
    if ({int_en_o, zero_o, carry_o, neg_o, parity_o, sticky, irq, stat_ready} !== 11'b1_0_0_0_00_000_0_1) begin
      miscompares++;
      $display("FAIL decode_e0: got %b required 1_0_0_0_00_000_0_1",
               {int_en_o, zero_o, carry_o, neg_o, parity_o, sticky, irq, stat_ready});
    end
    send_word(8'h6B);
    @(negedge clk);
    vectors++;
    if ({int_en_o, zero_o, carry_o, neg_o, parity_o, sticky, irq, stat_ready} !== 11'b0_0_1_0_11_010_0_1) begin
      miscompares++;
      $display("FAIL decode_6b: got %b required 0_0_1_0_11_010_0_1",
               {int_en_o, zero_o, carry_o, neg_o, parity_o, sticky, irq, stat_ready});
    end
    clr_sticky = 3'b010;
    @(negedge clk);
    clr_sticky = 3'b000;
    vectors++;
    if (sticky !== 3'b000) begin
      miscompares++;
      $display("FAIL clr_sticky: sticky=%b required 000", sticky);
    end
  endtask

  task automatic test_irq();
    send_word(8'hF0);
    @(negedge clk);
    vectors++;
    if ({zero_o, sticky, irq, stat_ready} !== 6'b1_100_1_0) begin
      miscompares++;
      $display("FAIL irq_raise: zero/sticky/irq/ready=%b required 1_100_1_0",
               {zero_o, sticky, irq, stat_ready});
    end
    // A word offered while not ready must be ignored.
    stat_valid = 1'b1;
    status     = 8'hE8;
    repeat (3) @(negedge clk);
    stat_valid = 1'b0;
    status     = 8'h00;
    vectors++;
    if ({irq, stat_ready, carry_o, zero_o} !== 4'b1_0_0_1) begin
      miscompares++;
      $display("FAIL irq_hold: irq/ready/carry/zero=%b required 1001", {irq, stat_ready, carry_o, zero_o});
    end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    vectors++;
    if ({irq, stat_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL irq_ack: irq/ready=%b required 01", {irq, stat_ready});
    end
  endtask

  task automatic test_back_to_back();
    send_word(8'hF0);
    @(negedge clk);
    vectors++;
    if ({irq, stat_ready, sticky} !== 5'b0_1_100) begin
      miscompares++;
      $display("FAIL already_sticky: irq/ready/sticky=%b required 0_1_100", {irq, stat_ready, sticky});
    end
    clr_sticky = 3'b100;
    @(negedge clk);
    clr_sticky = 3'b000;
    send_word(8'hF0);
    @(negedge clk);
    vectors++;
    if ({irq, sticky} !== 4'b1_100) begin
      miscompares++;
      $display("FAIL irq_rearm: irq/sticky=%b required 1_100", {irq, sticky});
    end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic test_frame_err();
    send_word(8'h94);
    @(negedge clk);
    vectors++;
    if ({frame_err, err_cnt, zero_o, int_en_o, neg_o, stat_ready} !== 9'b1_0001_1_1_0_1) begin
      miscompares++;
      $display("FAIL frame_err_first: got %b required 1_0001_1_1_0_1",
               {frame_err, err_cnt, zero_o, int_en_o, neg_o, stat_ready});
    end
    @(negedge clk);
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_err_pulse: frame_err=%0b required 0", frame_err);
    end
    for (int i = 0; i < 15; i++) begin
      send_word(8'h94);
      @(negedge clk);
    end
    vectors++;
    if (err_cnt !== 4'hF) begin
      miscompares++;
      $display("FAIL err_cnt_16: err_cnt=%h required f", err_cnt);
    end
    send_word(8'h14);
    @(negedge clk);
    vectors++;
    if ({frame_err, err_cnt} !== 5'b1_1111) begin
      miscompares++;
      $display("FAIL err_cnt_sat: frame_err/err_cnt=%b required 1_1111", {frame_err, err_cnt});
    end
  endtask

  task automatic test_collisions();
    clr_sticky = 3'b111;
    @(negedge clk);
    clr_sticky = 3'b000;
    send_word(8'h70);
    clr_sticky = 3'b100;
    @(negedge clk);
    clr_sticky = 3'b000;
    vectors++;
    if ({sticky, irq} !== 4'b100_0) begin
      miscompares++;
      $display("FAIL set_wins: sticky/irq=%b required 100_0", {sticky, irq});
    end
    send_word(8'h80);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if ({frame_err, err_cnt} !== 5'b1_0000) begin
      miscompares++;
      $display("FAIL err_clr_wins: frame_err/err_cnt=%b required 1_0000", {frame_err, err_cnt});
    end
    send_word(8'h00);
    @(negedge clk);
    vectors++;
    if (err_cnt !== 4'h1) begin
      miscompares++;
      $display("FAIL err_cnt_restart: err_cnt=%h required 1", err_cnt);
    end
  endtask

  task automatic test_async_reset();
    send_word(8'hF8);
    @(negedge clk);
    vectors++;
    if ({irq, sticky} !== 4'b1_110) begin
      miscompares++;
      $display("FAIL pre_reset_irq: irq/sticky=%b required 1_110", {irq, sticky});
    end
    #2 rstN = 1'b0;
    #1;
    vectors++;
    if ({irq, sticky, stat_ready, err_cnt, carry_o} !== 10'b0_000_1_0000_0) begin
      miscompares++;
      $display("FAIL async_reset: irq/sticky/ready/err_cnt/carry=%b required 0_000_1_0000_0",
               {irq, sticky, stat_ready, err_cnt, carry_o});
    end
    @(negedge clk);
    rstN = 1'b1;
    // A word captured just before reset must never be decoded.
    send_word(8'hF0);
    rstN = 1'b0;
    #2 rstN = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({zero_o, int_en_o, sticky, irq, stat_ready} !== 7'b0_0_000_0_1) begin
      miscompares++;
      $display("FAIL reset_drops_word: zero/int_en/sticky/irq/ready=%b required 0_0_000_0_1",
               {zero_o, int_en_o, sticky, irq, stat_ready});
    end
  endtask

  initial begin
    stat_valid = 1'b0;
    status     = 8'h00;
    clr_sticky = 3'b000;
    err_clr    = 1'b0;
    irq_ack    = 1'b0;
    rstN       = 1'b0;
    test_reset();
    test_decode();
    test_irq();
    test_back_to_back();
    test_frame_err();
    test_collisions();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
